// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//
// Drains a first-word-fall-through FIFO and shifts each entry out as an
// 8N1-style asynchronous frame: one start bit (0), DATA_WIDTH data bits
// LSB first, one stop bit (1). Every bit lasts 'period' clk cycles, where
// period is prescale (0 treated as 1) latched at the pop that starts the
// frame. Frames run back to back while the FIFO holds data.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   fifo_read_data FIFO head entry, valid whenever fifo_empty is low
//   fifo_empty     FIFO empty flag
//   fifo_read_en   pop strobe, one cycle per consumed entry (combinational)
//   prescale       bit period in clk cycles (0 behaves as 1)
//   txd            serial line, idle high, registered
//   busy           high while a frame is on the line, registered
//
// FIFO handshake: the FIFO offers data by holding fifo_empty low with
// fifo_read_data valid; this block accepts it by raising fifo_read_en. The
// entry is consumed on the rising clk edge where fifo_read_en is high. The
// strobe only rises when fifo_empty is low, so the FIFO is never popped empty.

module fifo_uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     fifo_read_data,
    input  logic                      fifo_empty,
    output logic                      fifo_read_en,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      txd,
    output logic                      busy
);

    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic [PRESCALE_WIDTH-1:0] period;
    logic [PRESCALE_WIDTH-1:0] bit_cnt;
    logic [IDX_W-1:0]          bit_idx;

    logic [PRESCALE_WIDTH-1:0] prescale_eff;
    logic [DATA_WIDTH-1:0]     shift_next;

    assign prescale_eff = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
    assign shift_next   = shift_reg >> 1;

    // Pop from IDLE, or in the last stop-bit cycle so the next start bit
    // follows with no gap. Forced low during reset.
    always_comb begin
        fifo_read_en = 1'b0;
        if (!rst && !fifo_empty) begin
            if (state == IDLE) begin
                fifo_read_en = 1'b1;
            end else if (state == STOP && bit_cnt == '0) begin
                fifo_read_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            period    <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
        end else if (fifo_read_en) begin
            // Pop edge: latch the byte and this frame's bit period, start bit begins now.
            shift_reg <= fifo_read_data;
            period    <= prescale_eff;
            bit_cnt   <= prescale_eff - PRESCALE_WIDTH'(1);
            bit_idx   <= '0;
            state     <= START;
            txd       <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                end
                START: begin
                    if (bit_cnt == '0) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        bit_cnt <= period - PRESCALE_WIDTH'(1);
                        txd     <= shift_reg[0];
                    end else begin
                        bit_cnt <= bit_cnt - PRESCALE_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == '0) begin
                        shift_reg <= shift_next;
                        bit_cnt   <= period - PRESCALE_WIDTH'(1);
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            txd     <= shift_next[0];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - PRESCALE_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt == '0) begin
                        // No queued entry (a queued one is taken by the pop branch).
                        state <= IDLE;
                        busy  <= 1'b0;
                        txd   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - PRESCALE_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//
// Drives fifo_uart_tx from a queue-based FWFT FIFO model and checks the
// serial line cycle by cycle. Bytes pushed into the FIFO model are also
// pushed to the expected queue; each received frame pops one expected byte.
// Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_fifo_uart_tx;

    localparam int W  = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  fifo_read_data;
    logic          fifo_empty;
    logic          fifo_read_en;
    logic [PW-1:0] prescale;
    logic          txd;
    logic          busy;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_read_data (fifo_read_data),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .prescale       (prescale),
        .txd            (txd),
        .busy           (busy)
    );

    // ---------------- FIFO model / driver tasks ----------------
    task automatic refresh();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [W-1:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        refresh();
    endtask

    // Advance from one falling edge to the next, popping the FIFO model on
    // the rising edge where fifo_read_en was high.
    task automatic tick();
        logic en;
        #1;
        en = fifo_read_en;
        @(posedge clk);
        if (en) begin
            if (fifo_q.size() == 0) begin
                bad++;
                $display("FAIL pop_while_empty: fifo_read_en=1 required 0");
            end else begin
                void'(fifo_q.pop_front());
            end
            pops++;
        end
        #1;
        refresh();
        @(negedge clk);
    endtask

    // Wait for a start bit, then check one full frame cycle by cycle.
    // gap = cycles waited before the start bit appeared.
    task automatic rx_frame(input int period, input int chg_c,
                            input logic [PW-1:0] chg_val, output int gap);
        logic [W-1:0] b;
        logic [W+1:0] frame_bits;
        int           bit_err, busy_err, en_err, c;
        logic         first_bad;
        gap = 0;
        while (txd !== 1'b0 && gap < 200) begin
            tick();
            gap++;
        end
        total++;
        if (txd !== 1'b0) begin
            bad++;
            $display("FAIL start_timeout: txd=%b required 0 within 200 cycles", txd);
            return;
        end
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_frame: got frame, expected queue empty");
            return;
        end
        b          = exp_q.pop_front();
        frame_bits = {1'b1, b, 1'b0};
        busy_err   = 0;
        en_err     = 0;
        for (int k = 0; k < W + 2; k++) begin
            bit_err   = 0;
            first_bad = 1'b0;
            for (int j = 0; j < period; j++) begin
                c = k * period + j;
                if (c == chg_c) prescale = chg_val;
                if (txd !== frame_bits[k]) begin
                    if (bit_err == 0) first_bad = txd;
                    bit_err++;
                end
                if (busy !== 1'b1) busy_err++;
                if (c == (W + 2) * period - 1) begin
                    if (fifo_read_en !== (fifo_q.size() != 0)) en_err++;
                end else if (fifo_read_en !== 1'b0) begin
                    en_err++;
                end
                tick();
            end
            total++;
            if (bit_err != 0) begin
                bad++;
                $display("FAIL frame_bit: byte=%h bit=%0d txd=%b required %b (%0d bad cycles)",
                         b, k, first_bad, frame_bits[k], bit_err);
            end
        end
        total++;
        if (busy_err != 0) begin
            bad++;
            $display("FAIL busy_in_frame: busy low %0d cycles, required high", busy_err);
        end
        total++;
        if (en_err != 0) begin
            bad++;
            $display("FAIL read_en_in_frame: %0d wrong cycles, required pop only at last stop cycle", en_err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        fifo_q.push_back(8'h11);
        refresh();
        #1;
        total++;
        if (fifo_read_en !== 1'b0) begin
            bad++; $display("FAIL reset_read_en: %b required 0", fifo_read_en);
        end
        total++;
        if (txd !== 1'b1) begin
            bad++; $display("FAIL reset_txd: %b required 1", txd);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: %b required 0", busy);
        end
        fifo_q.delete();
        refresh();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_empty_idle();
        int en_err = 0, txd_err = 0, busy_err = 0;
        for (int i = 0; i < 100; i++) begin
            if (fifo_read_en !== 1'b0) en_err++;
            if (txd !== 1'b1) txd_err++;
            if (busy !== 1'b0) busy_err++;
            tick();
        end
        total++;
        if (en_err != 0) begin bad++; $display("FAIL idle_read_en: %0d cycles high, required 0", en_err); end
        total++;
        if (txd_err != 0) begin bad++; $display("FAIL idle_txd: %0d cycles low, required 1", txd_err); end
        total++;
        if (busy_err != 0) begin bad++; $display("FAIL idle_busy: %0d cycles high, required 0", busy_err); end
    endtask

    task automatic test_single();
        int gap, p0;
        prescale = 16'd4;
        p0 = pops;
        push(8'hA5);
        #1;
        total++;
        if (fifo_read_en !== 1'b1) begin
            bad++; $display("FAIL single_read_en_rise: %b required 1", fifo_read_en);
        end
        rx_frame(4, -1, '0, gap);
        total++;
        if (pops - p0 != 1) begin bad++; $display("FAIL single_pops: %0d required 1", pops - p0); end
        total++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            bad++; $display("FAIL single_return_idle: busy=%b txd=%b required 0 1", busy, txd);
        end
    endtask

    task automatic test_back_to_back();
        int gap, p0;
        prescale = 16'd2;
        p0 = pops;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        rx_frame(2, -1, '0, gap);
        rx_frame(2, -1, '0, gap);
        total++;
        if (gap != 0) begin bad++; $display("FAIL b2b_gap2: %0d required 0", gap); end
        rx_frame(2, -1, '0, gap);
        total++;
        if (gap != 0) begin bad++; $display("FAIL b2b_gap3: %0d required 0", gap); end
        total++;
        if (pops - p0 != 3) begin bad++; $display("FAIL b2b_pops: %0d required 3", pops - p0); end
        total++;
        if (fifo_empty !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_end: fifo_empty=%b busy=%b required 1 0", fifo_empty, busy);
        end
    endtask

    task automatic test_prescale_zero();
        int gap;
        prescale = 16'd0;
        push(8'h81);
        rx_frame(1, -1, '0, gap);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ps0_end_busy: %b required 0", busy); end
    endtask

    task automatic test_prescale_max();
        int wait_c = 0, n = 0;
        prescale = 16'hFFFF;
        push(8'hFF);
        while (txd !== 1'b0 && wait_c < 200) begin tick(); wait_c++; end
        while (txd === 1'b0 && n < 70000) begin tick(); n++; end
        total++;
        if (n != 65535) begin bad++; $display("FAIL ps_max_start_len: %0d required 65535", n); end
        // Abort the long frame; that byte is discarded.
        rst = 1'b1;
        tick();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rst = 1'b0;
        tick();
    endtask

    task automatic test_prescale_change();
        int gap;
        prescale = 16'd3;
        push(8'h96);
        push(8'h4B);
        // Change prescale during data bit 1 of the first frame.
        rx_frame(3, 7, 16'd7, gap);
        rx_frame(7, -1, '0, gap);
        total++;
        if (gap != 0) begin bad++; $display("FAIL ps_change_gap: %0d required 0", gap); end
    endtask

    task automatic test_reset_mid();
        int wait_c = 0, p0, txd_err = 0;
        prescale = 16'd4;
        push(8'h3C);
        while (txd !== 1'b0 && wait_c < 200) begin tick(); wait_c++; end
        repeat (17) tick();   // now inside data bit 3 (cycles 16..19)
        total++;
        if (txd !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid_before: txd=%b busy=%b required 1 1", txd, busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_async: txd=%b busy=%b required 1 0", txd, busy);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        tick();
        tick();
        rst = 1'b0;
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            if (txd !== 1'b1) txd_err++;
            tick();
        end
        total++;
        if (pops != p0) begin bad++; $display("FAIL rst_mid_pops: %0d required 0", pops - p0); end
        total++;
        if (txd_err != 0) begin bad++; $display("FAIL rst_mid_txd: %0d low cycles, required 0", txd_err); end
    endtask

    initial begin
        rst      = 1'b1;
        prescale = 16'd4;
        refresh();
        @(negedge clk);
        test_reset();
        test_empty_idle();
        test_single();
        test_back_to_back();
        test_prescale_zero();
        test_prescale_change();
        test_reset_mid();
        test_prescale_max();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL leftover_expected: %0d bytes, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
